segment_chase_sequencer: RTL
============================

// Module: segment_chase_sequencer
// PURPOSE
//  Controller for the 7-segment figure-8 chase display. It schedules step timing and
//  holds a run/pause/idle state machine. It walks an 8-position segment path in one of
//  three modes and drives per-segment fade levels into a PWM output stage.
//  Sits between the io_in pins (clk, reset_n, mode/speed controls) and io_out; bit 7 of io_out is the DP pin.
// PARAMETERS
//  PRESCALE_SHIFT  16  step period = (speed_sel+1) << PRESCALE_SHIFT clocks
//  FADE_SHIFT      18  fade tick every 2**FADE_SHIFT clocks (free-running)
//  FADE_WIDTH      4   bits per segment level; max level = 2**FADE_WIDTH-1
//  COMMON_ANODE    1   1: led_out active-low, dp=1; 0: active-high, dp=0
// PORTS
//  clk        in   1  system clock (io_in[0])
//  reset_n    in   1  synchronous active-low reset
//  run        in   1  level; 1 = auto-step, 0 = pause
//  stop       in   1  pulse; return to IDLE from PAUSE
//  step_req   in   1  pulse; single step while in PAUSE
//  mode       in   2  00 chase fwd, 01 chase rev, 10 bounce, 11 reserved (= 00)
//  speed_sel  in   3  step period select, 0 = fastest
//  tail_en    in   1  1 = fading tail, 0 = only active segment lit
//  led_out    out  7  segment drive a..g (bit0=a)
//  dp         out  1  constant COMMON_ANODE
//  pos        out  3  current path index
//  step_stb   out  1  1-cycle pulse on every position advance
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): FSM=IDLE, pos=0, dir=fwd, prescaler=0, fade_cnt=0, pwm_cnt=0,
//   all levels=0, step_stb=0, led_out=all off (7'h7F if COMMON_ANODE else 7'h00). Reset overrides all inputs.
//  Path table pos->segment: 0:a 1:b 2:g 3:e 4:d 5:c 6:g 7:f (g visited twice).
//  FSM: IDLE --run=1--> RUN; RUN --run=0--> PAUSE; PAUSE --run=1--> RUN;
//   PAUSE --stop=1--> IDLE (clears pos, dir, levels, prescaler). IDLE: levels=0, no stepping.
//   If stop and run are both 1 in PAUSE, run wins.
//  Prescaler: counts only in RUN. When cnt >= period-1, cnt<=0 and one step occurs.
//   The >= compare makes a speed_sel decrease mid-count fire next cycle. Prescaler holds in PAUSE.
//  Step (RUN terminal, or PAUSE with step_req=1): pos updates at that edge; step_stb=1 the same cycle pos changes.
//   fwd: pos+1 mod 8; rev: pos-1 mod 8 (0->7). Modes 00 and 01 set dir directly.
//   bounce: move in dir; at pos=7 going fwd the next step is to 6 with dir=rev;
//   at pos=0 going rev the next step is to 1 with dir=fwd. No repeat at the ends.
//  Levels: each cycle outside IDLE, seg[path[pos]] <= max level.
//   On a fade tick with tail_en=1, all other segments shift right by 1.
//   Active-segment load beats fade on the same cycle.
//   With tail_en=0, non-active segments are 0 on every cycle.
//  PWM: pwm_cnt is a free-running FADE_WIDTH-bit counter. lit[i] = (level[i] > pwm_cnt).
//   led_out is registered: lit ^ {7{COMMON_ANODE}}.
//  Latency: step edge N: pos/step_stb at N; level at max at N+1; led_out reflects it from N+2.
//  mode/speed_sel/tail_en are sampled every cycle. A mode change takes effect on the next step.
//   Changing to bounce keeps the current dir.
// STRUCTURE
//  Package chaser_pkg: mode encodings, FSM enum {IDLE,RUN,PAUSE}, path table function.
//  Sub-module chaser_pwm_bank: 7 level registers, fade shift, PWM compare, output register.
//  Top level: FSM, prescaler, fade tick, pos/dir.
// TESTING (PRESCALE_SHIFT=2, FADE_SHIFT=3, FADE_WIDTH=4)
//  Reset with run=1 held -> led_out=7'h7F, pos=0, no step_stb until reset_n=1.
//  Reset released, run=1, mode=00, speed_sel=0 -> step_stb every 4 clk; pos 0,1,..,7,0; a,b,g,e,d,c,g,f lit in turn.
//  mode=10 from pos=5 -> pos 6,7,6,5,..,0,1; no repeated index at either end.
//  run=0 at pos=3 -> pos held, no step_stb; step_req pulse -> pos=4 with one step_stb.
//   stop pulse -> IDLE, pos=0, led_out all off within 2 clk.
//  tail_en=1 -> previous segment level 15,7,3,1,0 on successive fade ticks.
//   tail_en=0 -> only the active segment is nonzero; duty 15/16.
//  reset_n=0 mid-RUN at pos=6 -> next cycle all state is at reset values. speed_sel 7->0 with cnt=10 -> step on next clk.

Source files
------------

// File: rtl/chaser_pkg.sv
// Shared definitions for the segment chase sequencer.
//   - mode encodings for the mode input
//   - FSM state enum
//   - path table: path index (0..7) to segment index (0=a .. 6=g)
package chaser_pkg;

  localparam logic [1:0] MODE_FWD    = 2'b00;
  localparam logic [1:0] MODE_REV    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam int NUM_SEG = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Figure-8 walk: a b g e d c g f (g is crossed twice).
  function automatic logic [2:0] path_seg(input logic [2:0] p);
    logic [2:0] seg;
    case (p)
      3'd0:    seg = 3'd0; // a
      3'd1:    seg = 3'd1; // b
      3'd2:    seg = 3'd6; // g
      3'd3:    seg = 3'd4; // e
      3'd4:    seg = 3'd3; // d
      3'd5:    seg = 3'd2; // c
      3'd6:    seg = 3'd6; // g
      default: seg = 3'd5; // f
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/chaser_pwm_bank.sv
// Per-segment brightness store and PWM output stage.
//   clk, reset_n : clock, synchronous active-low reset
//   active       : 1 when the sequencer is outside IDLE; 0 forces all levels to 0
//   seg_idx      : segment currently under the chase head (loaded to max level)
//   fade_tick    : one-cycle pulse; halves every non-active level when tail_en=1
//   tail_en      : 1 keeps a decaying tail, 0 clears non-active segments
//   led_out      : registered segment drive a..g, polarity set by COMMON_ANODE
module chaser_pwm_bank
  import chaser_pkg::*;
#(
  parameter int FADE_WIDTH   = 4,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       active,
  input  logic [2:0] seg_idx,
  input  logic       fade_tick,
  input  logic       tail_en,
  output logic [6:0] led_out
);

  localparam logic [FADE_WIDTH-1:0] LVL_MAX = '1;
  localparam logic [6:0]            LED_OFF = {7{COMMON_ANODE}};

  logic [FADE_WIDTH-1:0] level_q [NUM_SEG];
  logic [FADE_WIDTH-1:0] level_d [NUM_SEG];
  logic [FADE_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [6:0]            led_q, led_d;
  logic [6:0]            lit;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    lit       = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      level_d[i] = '0;
      if (active) begin
        // Head load has priority over the fade on the same cycle.
        if (3'(i) == seg_idx) begin
          level_d[i] = LVL_MAX;
        end else if (tail_en) begin
          level_d[i] = fade_tick ? (level_q[i] >> 1) : level_q[i];
        end
      end
      lit[i] = (level_q[i] > pwm_cnt_q);
    end
    led_d = lit ^ LED_OFF;
  end

  // Stage boundary: levels and PWM counter -> registered segment drive
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
      led_q     <= LED_OFF;
      for (int i = 0; i < NUM_SEG; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      for (int i = 0; i < NUM_SEG; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign led_out = led_q;

endmodule

// File: rtl/segment_chase_sequencer.sv
// Figure-8 chase controller for a 7-segment display.
//   clk, reset_n : clock, synchronous active-low reset
//   run          : level, 1 = auto-step, 0 = pause
//   stop         : pulse, PAUSE -> IDLE (run has priority)
//   step_req     : pulse, single step while paused
//   mode         : 00 fwd, 01 rev, 10 bounce, 11 treated as fwd
//   speed_sel    : step period = (speed_sel+1) << PRESCALE_SHIFT clocks
//   tail_en      : 1 = fading tail behind the head
//   led_out      : segment drive a..g (bit0 = a)
//   dp           : decimal point, held at COMMON_ANODE
//   pos          : current path index
//   step_stb     : one-cycle pulse in the cycle pos changes
module segment_chase_sequencer
  import chaser_pkg::*;
#(
  parameter int PRESCALE_SHIFT = 16,
  parameter int FADE_SHIFT     = 18,
  parameter int FADE_WIDTH     = 4,
  parameter bit COMMON_ANODE   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       stop,
  input  logic       step_req,
  input  logic [1:0] mode,
  input  logic [2:0] speed_sel,
  input  logic       tail_en,
  output logic [6:0] led_out,
  output logic       dp,
  output logic [2:0] pos,
  output logic       step_stb
);

  // Wide enough for (7+1) << PRESCALE_SHIFT with headroom.
  localparam int CNT_W = PRESCALE_SHIFT + 4;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FADE_SHIFT-1:0] fade_cnt_q, fade_cnt_d;
  logic [2:0]            pos_q, pos_d;
  logic                  dir_rev_q, dir_rev_d;
  logic                  step_stb_q, step_stb_d;

  logic [CNT_W-1:0]      period_m1;
  logic                  do_step;
  logic                  clear;
  logic                  mv_rev;
  logic                  fade_tick;

  assign period_m1 = ((CNT_W'(speed_sel) + CNT_W'(1)) << PRESCALE_SHIFT) - CNT_W'(1);
  assign fade_tick = &fade_cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    dir_rev_d  = dir_rev_q;
    fade_cnt_d = fade_cnt_q + 1'b1;
    do_step    = 1'b0;
    clear      = 1'b0;
    mv_rev     = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) state_d = PAUSE;
        // >= rather than == so a shorter period chosen mid-count fires at once.
        if (cnt_q >= period_m1) begin
          cnt_d   = '0;
          do_step = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PAUSE: begin
        if (run) begin
          state_d = RUN;
        end else if (stop) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
        if (step_req && !clear) do_step = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      cnt_d     = '0;
      pos_d     = '0;
      dir_rev_d = 1'b0;
    end

    if (do_step) begin
      case (mode)
        MODE_REV:    mv_rev = 1'b1;
        MODE_BOUNCE: mv_rev = dir_rev_q;
        default:     mv_rev = 1'b0;
      endcase
      dir_rev_d = mv_rev;
      // Bounce turns around without repeating the end index.
      if (mode == MODE_BOUNCE && !mv_rev && pos_q == 3'd7) begin
        pos_d     = 3'd6;
        dir_rev_d = 1'b1;
      end else if (mode == MODE_BOUNCE && mv_rev && pos_q == 3'd0) begin
        pos_d     = 3'd1;
        dir_rev_d = 1'b0;
      end else begin
        pos_d = mv_rev ? (pos_q - 3'd1) : (pos_q + 3'd1);
      end
    end

    step_stb_d = do_step;
  end

  // Stage boundary: control state, prescaler, fade timer, position
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fade_cnt_q <= '0;
      pos_q      <= '0;
      dir_rev_q  <= 1'b0;
      step_stb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fade_cnt_q <= fade_cnt_d;
      pos_q      <= pos_d;
      dir_rev_q  <= dir_rev_d;
      step_stb_q <= step_stb_d;
    end
  end

  chaser_pwm_bank #(
    .FADE_WIDTH   (FADE_WIDTH),
    .COMMON_ANODE (COMMON_ANODE)
  ) u_pwm_bank (
    .clk       (clk),
    .reset_n   (reset_n),
    .active    (state_q != IDLE),
    .seg_idx   (path_seg(pos_q)),
    .fade_tick (fade_tick),
    .tail_en   (tail_en),
    .led_out   (led_out)
  );

  assign pos      = pos_q;
  assign step_stb = step_stb_q;
  assign dp       = COMMON_ANODE;

endmodule
